// File: rtl/accel_pkg.sv
// Shared types and constants for the editing-accelerator command sequencer.
package accel_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StRun   = 2'd2,
      StDrain = 2'd3
   } state_e;

   typedef enum logic {
      ModeParam = 1'b0,
      ModeImg   = 1'b1
   } mode_e;

   localparam logic [1:0] CMD_CLR   = 2'd0;
   localparam logic [1:0] CMD_PARAM = 2'd1;
   localparam logic [1:0] CMD_IMG   = 2'd2;
   localparam logic [1:0] CMD_RUN   = 2'd3;

   localparam int unsigned STAT_BUSY      = 7;
   localparam int unsigned STAT_PARAMS_OK = 6;
   localparam int unsigned STAT_IMG_OK    = 5;
   localparam int unsigned STAT_LEN_ERR   = 4;
   localparam int unsigned STAT_CMD_ERR   = 3;
   localparam int unsigned STAT_DONE      = 2;

   localparam int unsigned PARAM_BEATS_DEF = 12672;
   localparam int unsigned IMG_BEATS_DEF   = 576;
   localparam int unsigned OUT_BEATS_DEF   = 576;
   localparam int unsigned AW_DEF          = 14;

endpackage

// File: rtl/accel_seq_ctrl_if.sv
// Control, stream-handshake and buffer-write signals of the command sequencer.
interface accel_seq_ctrl_if #(
   parameter int unsigned AW = accel_pkg::AW_DEF
);
   logic          cmd_valid;
   logic [1:0]    cmd_code;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tready;
   logic          param_we;
   logic          img_we;
   logic [AW-1:0] wr_addr;
   logic          core_start;
   logic          core_done;
   logic          out_en;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [7:0]    status;

   // Sequencer side
   modport slave (
      input  cmd_valid, cmd_code, s_axis_tvalid, s_axis_tlast, core_done,
             m_axis_tvalid, m_axis_tready,
      output s_axis_tready, param_we, img_we, wr_addr, core_start, out_en,
             m_axis_tlast, status
   );

   // Environment side (AXI-Lite slave, streams, core)
   modport master (
      output cmd_valid, cmd_code, s_axis_tvalid, s_axis_tlast, core_done,
             m_axis_tvalid, m_axis_tready,
      input  s_axis_tready, param_we, img_we, wr_addr, core_start, out_en,
             m_axis_tlast, status
   );
endinterface

// File: rtl/accel_seq_ctrl_beat_counter.sv
// Resettable up-counter with clear and a terminal flag at limit-1.
module beat_counter #(
   parameter int unsigned W = 14
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc,
   input  logic         clr,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         last
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign last  = (count_q == limit - 1'b1);

endmodule

// File: rtl/accel_seq_ctrl.sv
// Command sequencer: decodes register-0 commands, steers the input stream into the
// parameter/image buffers, starts the core and frames the output stream.
module accel_seq_ctrl
   import accel_pkg::*;
#(
   parameter int unsigned PARAM_BEATS = PARAM_BEATS_DEF,
   parameter int unsigned IMG_BEATS   = IMG_BEATS_DEF,
   parameter int unsigned OUT_BEATS   = OUT_BEATS_DEF,
   parameter int unsigned AW          = AW_DEF
) (
   input logic             clk,
   input logic             rstn,
   accel_seq_ctrl_if.slave bus
);

   localparam logic [AW-1:0] ParamLim = AW'(PARAM_BEATS);
   localparam logic [AW-1:0] ImgLim   = AW'(IMG_BEATS);
   localparam logic [AW-1:0] OutLim   = AW'(OUT_BEATS);

   state_e state_q, state_d;
   mode_e  mode_q, mode_d;
   logic   params_ok_q, params_ok_d;
   logic   img_ok_q, img_ok_d;
   logic   len_err_q, len_err_d;
   logic   cmd_err_q, cmd_err_d;
   logic   done_q, done_d;
   logic   start_q, start_d;

   logic          load_hs, drain_hs;
   logic          load_last, drain_last;
   logic [AW-1:0] load_cnt, drain_cnt, load_lim;

   assign load_hs  = (state_q == StLoad) && bus.s_axis_tvalid;
   assign drain_hs = (state_q == StDrain) && bus.m_axis_tvalid && bus.m_axis_tready;
   assign load_lim = (mode_q == ModeParam) ? ParamLim : ImgLim;

   beat_counter #(.W(AW)) u_load_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (load_hs),
      .clr   (state_q == StIdle),
      .limit (load_lim),
      .count (load_cnt),
      .last  (load_last)
   );

   beat_counter #(.W(AW)) u_drain_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (drain_hs),
      .clr   (state_q != StDrain),
      .limit (OutLim),
      .count (drain_cnt),
      .last  (drain_last)
   );

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      params_ok_d = params_ok_q;
      img_ok_d    = img_ok_q;
      len_err_d   = len_err_q;
      cmd_err_d   = cmd_err_q;
      done_d      = done_q;
      start_d     = 1'b0;

      // Command decode first so that same-cycle datapath events can still set flags.
      if (bus.cmd_valid) begin
         if (state_q == StIdle) begin
            unique case (bus.cmd_code)
               CMD_CLR: begin
                  len_err_d = 1'b0;
                  cmd_err_d = 1'b0;
                  done_d    = 1'b0;
               end
               CMD_PARAM: begin
                  state_d     = StLoad;
                  mode_d      = ModeParam;
                  params_ok_d = 1'b0;
               end
               CMD_IMG: begin
                  state_d  = StLoad;
                  mode_d   = ModeImg;
                  img_ok_d = 1'b0;
               end
               CMD_RUN: begin
                  if (params_ok_q && img_ok_q) begin
                     state_d = StRun;
                     start_d = 1'b1;
                  end else begin
                     cmd_err_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (bus.cmd_code == CMD_CLR) begin
            len_err_d = 1'b0;
            cmd_err_d = 1'b0;
            done_d    = 1'b0;
         end else begin
            cmd_err_d = 1'b1;
         end
      end

      unique case (state_q)
         StLoad: begin
            if (load_hs) begin
               if (load_last) begin
                  state_d = StIdle;
                  if (mode_q == ModeParam) params_ok_d = 1'b1;
                  else                     img_ok_d    = 1'b1;
                  if (!bus.s_axis_tlast) len_err_d = 1'b1;
               end else if (bus.s_axis_tlast) begin
                  state_d   = StIdle;
                  len_err_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (bus.core_done) state_d = StDrain;
         end
         StDrain: begin
            if (drain_hs && drain_last) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= StIdle;
         mode_q      <= ModeParam;
         params_ok_q <= 1'b0;
         img_ok_q    <= 1'b0;
         len_err_q   <= 1'b0;
         cmd_err_q   <= 1'b0;
         done_q      <= 1'b0;
         start_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         params_ok_q <= params_ok_d;
         img_ok_q    <= img_ok_d;
         len_err_q   <= len_err_d;
         cmd_err_q   <= cmd_err_d;
         done_q      <= done_d;
         start_q     <= start_d;
      end
   end

   assign bus.s_axis_tready = (state_q == StLoad);
   assign bus.param_we      = load_hs && (mode_q == ModeParam);
   assign bus.img_we        = load_hs && (mode_q == ModeImg);
   assign bus.wr_addr       = load_cnt;
   assign bus.core_start    = start_q;
   assign bus.out_en        = (state_q == StDrain);
   assign bus.m_axis_tlast  = (state_q == StDrain) && drain_last && bus.m_axis_tvalid;

   always_comb begin
      bus.status                 = '0;
      bus.status[STAT_BUSY]      = (state_q != StIdle);
      bus.status[STAT_PARAMS_OK] = params_ok_q;
      bus.status[STAT_IMG_OK]    = img_ok_q;
      bus.status[STAT_LEN_ERR]   = len_err_q;
      bus.status[STAT_CMD_ERR]   = cmd_err_q;
      bus.status[STAT_DONE]      = done_q;
      bus.status[1:0]            = state_q;
   end

   drain_in_range: assert property (@(posedge clk) disable iff (!rstn)
      (state_q == StDrain) |-> (drain_cnt < OutLim));

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Self-checking bench for accel_seq_ctrl with a flag-level reference model.
module tb_accel_seq_ctrl;

   localparam int unsigned NP = 12672;
   localparam int unsigned NI = 576;
   localparam int unsigned NO = 576;
   localparam int unsigned AW = 14;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   accel_seq_ctrl_if #(.AW(AW)) bus ();

   accel_seq_ctrl #(
      .PARAM_BEATS (NP),
      .IMG_BEATS   (NI),
      .OUT_BEATS   (NO),
      .AW          (AW)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: the status flags as the command rules define them
   bit m_params_ok, m_img_ok, m_len_err, m_cmd_err, m_done;

   function automatic logic [7:0] exp_status(input bit busy, input logic [1:0] st);
      return {busy, m_params_ok, m_img_ok, m_len_err, m_cmd_err, m_done, st};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] code);
      bus.cmd_valid = 1'b1;
      bus.cmd_code  = code;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.cmd_valid     = 1'b0;
      bus.cmd_code      = 2'd0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      bus.core_done     = 1'b0;
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tready = 1'b0;
      rstn = 1'b0;
      {m_params_ok, m_img_ok, m_len_err, m_cmd_err, m_done} = '0;
      tick();
      tick();
      total++;
      if (bus.status !== 8'h00) begin
         bad++;
         $display("FAIL reset_status: got %h want 00", bus.status);
      end
      total++;
      if ({bus.s_axis_tready, bus.param_we, bus.img_we, bus.core_start, bus.out_en,
           bus.m_axis_tlast} !== 6'b0 || bus.wr_addr !== '0) begin
         bad++;
         $display("FAIL reset_outputs: tready=%b pwe=%b iwe=%b start=%b oen=%b tlast=%b addr=%0d want all 0",
                  bus.s_axis_tready, bus.param_we, bus.img_we, bus.core_start, bus.out_en,
                  bus.m_axis_tlast, bus.wr_addr);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_run_without_loads();
      send_cmd(2'd3);
      m_cmd_err = 1'b1;
      #1;
      total++;
      if (bus.core_start !== 1'b0) begin
         bad++;
         $display("FAIL run_noload_start: got %b want 0", bus.core_start);
      end
      total++;
      if (bus.status !== exp_status(1'b0, 2'd0)) begin
         bad++;
         $display("FAIL run_noload_status: got %h want %h", bus.status, exp_status(1'b0, 2'd0));
      end
      send_cmd(2'd0);
      {m_len_err, m_cmd_err, m_done} = '0;
      #1;
      total++;
      if (bus.status !== exp_status(1'b0, 2'd0)) begin
         bad++;
         $display("FAIL clear_status: got %h want %h", bus.status, exp_status(1'b0, 2'd0));
      end
   endtask

   task automatic test_param_load();
      int n_we  = 0;
      int n_err = 0;
      send_cmd(2'd1);
      m_params_ok = 1'b0;
      #1;
      total++;
      if (bus.s_axis_tready !== 1'b1 || bus.status !== exp_status(1'b1, 2'd1)) begin
         bad++;
         $display("FAIL param_enter: tready=%b status=%h want 1/%h", bus.s_axis_tready,
                  bus.status, exp_status(1'b1, 2'd1));
      end
      for (int i = 0; i < NP; i++) begin
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tlast  = (i == NP - 1);
         #1;
         if (bus.param_we === 1'b1 && bus.img_we === 1'b0 && bus.wr_addr === i[AW-1:0]) n_we++;
         else n_err++;
         tick();
      end
      bus.s_axis_tlast = 1'b0;
      m_params_ok = 1'b1;
      #1;
      total++;
      if (n_we != NP || n_err != 0) begin
         bad++;
         $display("FAIL param_writes: good=%0d bad_beats=%0d want %0d/0", n_we, n_err, NP);
      end
      // tvalid still high while idle must not write
      total++;
      if (bus.param_we !== 1'b0 || bus.s_axis_tready !== 1'b0 ||
          bus.status !== exp_status(1'b0, 2'd0)) begin
         bad++;
         $display("FAIL param_after: pwe=%b tready=%b status=%h want 0/0/%h", bus.param_we,
                  bus.s_axis_tready, bus.status, exp_status(1'b0, 2'd0));
      end
      bus.s_axis_tvalid = 1'b0;
   endtask

   task automatic test_img_load_gaps();
      int   beats  = 0;
      int   cycles = 0;
      int   n_we   = 0;
      int   n_err  = 0;
      logic v;
      send_cmd(2'd2);
      m_img_ok = 1'b0;
      while (beats < NI && cycles < 5000) begin
         v = 1'($urandom_range(0, 1));
         bus.s_axis_tvalid = v;
         bus.s_axis_tlast  = v && (beats == NI - 1);
         #1;
         if (bus.img_we !== v || bus.param_we !== 1'b0 || bus.s_axis_tready !== 1'b1 ||
             (v && bus.wr_addr !== beats[AW-1:0])) n_err++;
         if (bus.img_we === 1'b1) n_we++;
         if (v) beats++;
         tick();
         cycles++;
      end
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      m_img_ok = 1'b1;
      #1;
      total++;
      if (beats != NI) begin
         bad++;
         $display("FAIL img_timeout: beats=%0d want %0d", beats, NI);
      end
      total++;
      if (n_we != NI || n_err != 0) begin
         bad++;
         $display("FAIL img_writes: pulses=%0d bad_cycles=%0d want %0d/0", n_we, n_err, NI);
      end
      total++;
      if (bus.status !== exp_status(1'b0, 2'd0)) begin
         bad++;
         $display("FAIL img_status: got %h want %h", bus.status, exp_status(1'b0, 2'd0));
      end
   endtask

   task automatic test_run_drain();
      int   k      = 0;
      int   cycles = 0;
      int   n_err  = 0;
      logic tv, tr, exp_last;
      bus.core_done = 1'b1;
      tick();
      bus.core_done = 1'b0;
      #1;
      total++;
      if (bus.status !== exp_status(1'b0, 2'd0)) begin
         bad++;
         $display("FAIL done_in_idle: got %h want %h", bus.status, exp_status(1'b0, 2'd0));
      end
      send_cmd(2'd3);
      #1;
      total++;
      if (bus.core_start !== 1'b1 || bus.status !== exp_status(1'b1, 2'd2)) begin
         bad++;
         $display("FAIL run_start: start=%b status=%h want 1/%h", bus.core_start, bus.status,
                  exp_status(1'b1, 2'd2));
      end
      tick();
      total++;
      if (bus.core_start !== 1'b0) begin
         bad++;
         $display("FAIL start_width: got %b want 0", bus.core_start);
      end
      repeat ($urandom_range(0, 5)) tick();
      bus.core_done = 1'b1;
      tick();
      bus.core_done = 1'b0;
      #1;
      total++;
      if (bus.out_en !== 1'b1 || bus.status !== exp_status(1'b1, 2'd3)) begin
         bad++;
         $display("FAIL drain_enter: out_en=%b status=%h want 1/%h", bus.out_en, bus.status,
                  exp_status(1'b1, 2'd3));
      end
      while (k < NO && cycles < 10000) begin
         tv = 1'($urandom_range(0, 1));
         tr = ($urandom_range(0, 3) != 0);
         bus.m_axis_tvalid = tv;
         bus.m_axis_tready = tr;
         #1;
         exp_last = tv && (k == NO - 1);
         if (bus.m_axis_tlast !== exp_last || bus.out_en !== 1'b1) n_err++;
         if (tv && tr) k++;
         tick();
         cycles++;
      end
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tready = 1'b0;
      m_done = 1'b1;
      #1;
      total++;
      if (k != NO || n_err != 0) begin
         bad++;
         $display("FAIL drain_frame: beats=%0d bad_cycles=%0d want %0d/0", k, n_err, NO);
      end
      total++;
      if (bus.status !== exp_status(1'b0, 2'd0) || bus.out_en !== 1'b0) begin
         bad++;
         $display("FAIL drain_status: got %h out_en=%b want %h/0", bus.status, bus.out_en,
                  exp_status(1'b0, 2'd0));
      end
      // Repeat run with no reload and a zero-latency core
      send_cmd(2'd3);
      bus.core_done = 1'b1;
      #1;
      total++;
      if (bus.core_start !== 1'b1) begin
         bad++;
         $display("FAIL rerun_start: got %b want 1", bus.core_start);
      end
      tick();
      bus.core_done = 1'b0;
      #1;
      total++;
      if (bus.status !== exp_status(1'b1, 2'd3)) begin
         bad++;
         $display("FAIL rerun_drain: got %h want %h", bus.status, exp_status(1'b1, 2'd3));
      end
      n_err = 0;
      for (int j = 0; j < NO; j++) begin
         bus.m_axis_tvalid = 1'b1;
         bus.m_axis_tready = 1'b1;
         #1;
         if (bus.m_axis_tlast !== (j == NO - 1)) n_err++;
         tick();
      end
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tready = 1'b0;
      #1;
      total++;
      if (n_err != 0 || bus.status !== exp_status(1'b0, 2'd0)) begin
         bad++;
         $display("FAIL rerun_frame: bad_cycles=%0d status=%h want 0/%h", n_err, bus.status,
                  exp_status(1'b0, 2'd0));
      end
   endtask

   task automatic test_early_tlast();
      int n_we = 0;
      send_cmd(2'd2);
      m_img_ok = 1'b0;
      for (int i = 0; i <= 100; i++) begin
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tlast  = (i == 100);
         #1;
         if (bus.img_we === 1'b1) n_we++;
         tick();
      end
      bus.s_axis_tlast = 1'b0;
      m_len_err = 1'b1;
      #1;
      if (bus.img_we === 1'b1) n_we++;
      bus.s_axis_tvalid = 1'b0;
      total++;
      if (n_we != 101) begin
         bad++;
         $display("FAIL early_writes: got %0d want 101", n_we);
      end
      total++;
      if (bus.status !== exp_status(1'b0, 2'd0)) begin
         bad++;
         $display("FAIL early_status: got %h want %h", bus.status, exp_status(1'b0, 2'd0));
      end
      send_cmd(2'd0);
      {m_len_err, m_cmd_err, m_done} = '0;
      #1;
      total++;
      if (bus.status !== exp_status(1'b0, 2'd0)) begin
         bad++;
         $display("FAIL early_clear: got %h want %h", bus.status, exp_status(1'b0, 2'd0));
      end
   endtask

   task automatic test_cmd_during_load();
      int n_we = 0;
      send_cmd(2'd2);
      m_img_ok = 1'b0;
      for (int i = 0; i < NI; i++) begin
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tlast  = 1'b0;
         bus.cmd_valid     = (i == 200);
         bus.cmd_code      = 2'd1;
         #1;
         if (bus.img_we === 1'b1 && bus.param_we === 1'b0) n_we++;
         tick();
      end
      bus.cmd_valid     = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      m_cmd_err = 1'b1;
      m_len_err = 1'b1;
      m_img_ok  = 1'b1;
      #1;
      total++;
      if (n_we != NI) begin
         bad++;
         $display("FAIL busy_cmd_writes: got %0d want %0d", n_we, NI);
      end
      total++;
      if (bus.status !== exp_status(1'b0, 2'd0)) begin
         bad++;
         $display("FAIL busy_cmd_status: got %h want %h", bus.status, exp_status(1'b0, 2'd0));
      end
   endtask

   task automatic test_reset_mid_load();
      send_cmd(2'd1);
      m_params_ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         bus.s_axis_tvalid = 1'b1;
         tick();
      end
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      bus.s_axis_tvalid = 1'b0;
      {m_params_ok, m_img_ok, m_len_err, m_cmd_err, m_done} = '0;
      #1;
      total++;
      if (bus.status !== 8'h00 || bus.s_axis_tready !== 1'b0 || bus.wr_addr !== '0) begin
         bad++;
         $display("FAIL midreset: status=%h tready=%b addr=%0d want 00/0/0", bus.status,
                  bus.s_axis_tready, bus.wr_addr);
      end
      send_cmd(2'd3);
      m_cmd_err = 1'b1;
      #1;
      total++;
      if (bus.status !== exp_status(1'b0, 2'd0) || bus.core_start !== 1'b0) begin
         bad++;
         $display("FAIL midreset_run: status=%h start=%b want %h/0", bus.status,
                  bus.core_start, exp_status(1'b0, 2'd0));
      end
   endtask

   initial begin
      test_reset();
      test_run_without_loads();
      test_param_load();
      test_img_load_gaps();
      test_run_drain();
      test_early_tlast();
      test_cmd_during_load();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
